// File: rtl/ras_shadow_stack_mc_if.sv
// Request/response bundle for the multi-channel return-address shadow stack.
//   i_ch / i_push / i_push_data / i_pop / i_chk_data / i_clr / i_err_clr : requests
//   o_top / o_full / o_empty / o_chk_valid / o_chk_fail / o_err_*         : status
// master = requester (core / bench), slave = stack.
interface ras_shadow_stack_mc_if #(
    parameter int DATA_W = 64,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   i_ch;
    logic              i_push;
    logic [DATA_W-1:0] i_push_data;
    logic              i_pop;
    logic [DATA_W-1:0] i_chk_data;
    logic              i_clr;
    logic              i_err_clr;
    logic [DATA_W-1:0] o_top;
    logic [NUM_CH-1:0] o_full;
    logic [NUM_CH-1:0] o_empty;
    logic              o_chk_valid;
    logic              o_chk_fail;
    logic              o_err_overflow;
    logic              o_err_underflow;

    modport master (
        output i_ch, i_push, i_push_data, i_pop, i_chk_data, i_clr, i_err_clr,
        input  o_top, o_full, o_empty, o_chk_valid, o_chk_fail,
               o_err_overflow, o_err_underflow
    );

    modport slave (
        input  i_ch, i_push, i_push_data, i_pop, i_chk_data, i_clr, i_err_clr,
        output o_top, o_full, o_empty, o_chk_valid, o_chk_fail,
               o_err_overflow, o_err_underflow
    );
endinterface

// File: rtl/ras_shadow_stack_mc.sv
// Multi-channel return-address shadow stack. One circular stack per channel;
// calls push, returns pop and compare the popped address against the real
// return target. Check result is a registered pulse one cycle after the pop.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : ras_shadow_stack_mc_if.slave (requests in, top/full/empty/check/errors out)
module ras_shadow_stack_mc #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int NUM_CH    = 2,
    parameter int OVERWRITE = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    ras_shadow_stack_mc_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Storage has no reset so it maps onto distributed RAM.
    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wp_q  [NUM_CH];
    logic [PTR_W-1:0]  wp_d  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    logic chk_valid_q, chk_valid_d;
    logic chk_fail_q,  chk_fail_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic set_ovf, set_unf;

    logic [CH_W-1:0]   ch;
    logic              ch_ok;
    logic [PTR_W-1:0]  cur_wp, top_addr, waddr;
    logic [CNT_W-1:0]  cur_cnt;
    logic              is_empty, is_full, we;
    logic [DATA_W-1:0] top;
    logic [NUM_CH-1:0] full_v, empty_v;

    assign ch       = bus.i_ch;
    // Channel codes beyond NUM_CH (non power-of-two counts) are ignored.
    assign ch_ok    = (int'(ch) < NUM_CH);
    assign cur_wp   = wp_q[ch];
    assign cur_cnt  = cnt_q[ch];
    assign top_addr = cur_wp - 1'b1;
    assign is_empty = (cur_cnt == '0);
    assign is_full  = (cur_cnt == CNT_FULL);
    assign top      = is_empty ? '0 : mem_q[ch][top_addr];

    always_comb begin
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        we          = 1'b0;
        waddr       = cur_wp;
        chk_valid_d = 1'b0;
        chk_fail_d  = 1'b0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        if (ch_ok && bus.i_clr) begin
            wp_d[ch]  = '0;
            cnt_d[ch] = '0;
        end else if (ch_ok && bus.i_pop) begin
            chk_valid_d = 1'b1;
            if (is_empty) begin
                chk_fail_d = 1'b1;
                set_unf    = 1'b1;
                // Push in the same cycle still lands on the now-empty stack.
                if (bus.i_push) begin
                    we        = 1'b1;
                    wp_d[ch]  = cur_wp + 1'b1;
                    cnt_d[ch] = cur_cnt + 1'b1;
                end
            end else begin
                chk_fail_d = (top != bus.i_chk_data);
                if (bus.i_push) begin
                    // Return-then-call: replace the top in place.
                    we    = 1'b1;
                    waddr = top_addr;
                end else begin
                    wp_d[ch]  = top_addr;
                    cnt_d[ch] = cur_cnt - 1'b1;
                end
            end
        end else if (ch_ok && bus.i_push) begin
            if (!is_full) begin
                we        = 1'b1;
                wp_d[ch]  = cur_wp + 1'b1;
                cnt_d[ch] = cur_cnt + 1'b1;
            end else begin
                set_ovf = 1'b1;
                if (OVERWRITE != 0) begin
                    // wp lands on the oldest slot; count stays at DEPTH.
                    we       = 1'b1;
                    wp_d[ch] = cur_wp + 1'b1;
                end
            end
        end
        // Sticky flags: a set in the same cycle beats the clear.
        ovf_d = set_ovf | (ovf_q & ~bus.i_err_clr);
        unf_d = set_unf | (unf_q & ~bus.i_err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wp_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            chk_valid_q <= 1'b0;
            chk_fail_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            chk_valid_q <= chk_valid_d;
            chk_fail_q  <= chk_fail_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && we) mem_q[ch][waddr] <= bus.i_push_data;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full_v[c]  = (cnt_q[c] == CNT_FULL);
            empty_v[c] = (cnt_q[c] == '0);
        end
    end

    assign bus.o_top           = top;
    assign bus.o_full          = full_v;
    assign bus.o_empty         = empty_v;
    assign bus.o_chk_valid     = chk_valid_q;
    assign bus.o_chk_fail      = chk_fail_q;
    assign bus.o_err_overflow  = ovf_q;
    assign bus.o_err_underflow = unf_q;
endmodule

// File: tb/tb_ras_shadow_stack_mc.sv
// Bench for ras_shadow_stack_mc: two instances (drop-when-full and overwrite)
// share one stimulus stream; each is compared with a queue-based stack model.
module tb_ras_shadow_stack_mc;
    localparam int DW = 64, DEPTH = 16, NCH = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ras_shadow_stack_mc_if #(.DATA_W(DW), .NUM_CH(NCH)) bus0();
    ras_shadow_stack_mc_if #(.DATA_W(DW), .NUM_CH(NCH)) bus1();

    ras_shadow_stack_mc #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .OVERWRITE(0))
        dut0 (.clk(clk), .rstn(rstn), .bus(bus0.slave));
    ras_shadow_stack_mc #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .OVERWRITE(1))
        dut1 (.clk(clk), .rstn(rstn), .bus(bus1.slave));

    int n_chk = 0, n_pass = 0;

    // Model: one queue per (instance, channel); back of the queue is the top.
    logic [DW-1:0] mq [2*NCH][$];
    bit m_cv [2], m_cf [2], m_ovf [2], m_unf [2];

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(int ch, bit push, logic [DW-1:0] pd, bit pop,
                         logic [DW-1:0] cd, bit clr, bit eclr);
        bus0.i_ch = ch[0];  bus1.i_ch = ch[0];
        bus0.i_push = push; bus1.i_push = push;
        bus0.i_push_data = pd; bus1.i_push_data = pd;
        bus0.i_pop = pop;   bus1.i_pop = pop;
        bus0.i_chk_data = cd; bus1.i_chk_data = cd;
        bus0.i_clr = clr;   bus1.i_clr = clr;
        bus0.i_err_clr = eclr; bus1.i_err_clr = eclr;
    endtask

    task automatic model_op(int d, int ch, bit push, logic [DW-1:0] pd, bit pop,
                            logic [DW-1:0] cd, bit clr, bit eclr);
        int k = d*NCH + ch;
        bit so = 0, su = 0;
        m_cv[d] = 0;
        m_cf[d] = 0;
        if (clr) begin
            mq[k].delete();
        end else if (pop) begin
            m_cv[d] = 1;
            if (mq[k].size() == 0) begin
                m_cf[d] = 1;
                su = 1;
                if (push) mq[k].push_back(pd);
            end else begin
                m_cf[d] = (mq[k][$] != cd);
                if (push) mq[k][$] = pd;
                else void'(mq[k].pop_back());
            end
        end else if (push) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(pd);
            else begin
                so = 1;
                if (d == 1) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(pd);
                end
            end
        end
        m_ovf[d] = so | (m_ovf[d] & !eclr);
        m_unf[d] = su | (m_unf[d] & !eclr);
    endtask

    function automatic logic [DW-1:0] mtop(int d, int ch);
        int k = d*NCH + ch;
        return (mq[k].size() != 0) ? mq[k][$] : '0;
    endfunction

    task automatic compare(int d, int ch);
        logic [DW-1:0] top;
        logic [NCH-1:0] full, empty, efull, eempty;
        logic cv, cf, ov, un;
        if (d == 0) begin
            top = bus0.o_top; full = bus0.o_full; empty = bus0.o_empty;
            cv = bus0.o_chk_valid; cf = bus0.o_chk_fail;
            ov = bus0.o_err_overflow; un = bus0.o_err_underflow;
        end else begin
            top = bus1.o_top; full = bus1.o_full; empty = bus1.o_empty;
            cv = bus1.o_chk_valid; cf = bus1.o_chk_fail;
            ov = bus1.o_err_overflow; un = bus1.o_err_underflow;
        end
        for (int c = 0; c < NCH; c++) begin
            efull[c]  = (mq[d*NCH+c].size() == DEPTH);
            eempty[c] = (mq[d*NCH+c].size() == 0);
        end
        check($sformatf("u%0d chk_valid", d), DW'(cv), DW'(m_cv[d]));
        if (m_cv[d]) check($sformatf("u%0d chk_fail", d), DW'(cf), DW'(m_cf[d]));
        check($sformatf("u%0d err_overflow", d), DW'(ov), DW'(m_ovf[d]));
        check($sformatf("u%0d err_underflow", d), DW'(un), DW'(m_unf[d]));
        check($sformatf("u%0d full", d), DW'(full), DW'(efull));
        check($sformatf("u%0d empty", d), DW'(empty), DW'(eempty));
        check($sformatf("u%0d top ch%0d", d, ch), top, mtop(d, ch));
    endtask

    task automatic step(int ch, bit push, logic [DW-1:0] pd, bit pop,
                        logic [DW-1:0] cd, bit clr, bit eclr);
        drive(ch, push, pd, pop, cd, clr, eclr);
        for (int d = 0; d < 2; d++) model_op(d, ch, push, pd, pop, cd, clr, eclr);
        @(posedge clk);
        #1;
        drive(ch, 0, '0, 0, '0, 0, 0);
        for (int d = 0; d < 2; d++) compare(d, ch);
    endtask

    // Reset edge, optionally with a pop and push presented at the same time.
    task automatic do_reset(bit ops);
        rstn = 1'b0;
        drive(0, ops, 64'hdead, ops, 64'hbeef, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2*NCH; k++) mq[k].delete();
        for (int d = 0; d < 2; d++) begin
            m_cv[d] = 0; m_cf[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
        end
        drive(0, 0, '0, 0, '0, 0, 0);
        for (int d = 0; d < 2; d++) compare(d, 0);
        rstn = 1'b1;
    endtask

    initial begin
        drive(0, 0, '0, 0, '0, 0, 0);
        do_reset(1);

        // Basic push/push/pop with matching check.
        step(0, 1, 64'h1000, 0, '0, 0, 0);
        step(0, 1, 64'h2000, 0, '0, 0, 0);
        step(0, 0, '0, 1, 64'h2000, 0, 0);
        // Mismatch, then channel isolation.
        step(0, 1, 64'hA0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 64'hB0, 0, 0);
        step(1, 1, 64'h1, 0, '0, 0, 0);
        step(0, 0, '0, 1, 64'h1000, 0, 0);
        step(1, 0, '0, 0, '0, 0, 0);

        // Fill past full, then drain and underflow once more.
        step(0, 0, '0, 0, '0, 1, 1);
        for (int i = 1; i <= 17; i++) step(0, 1, DW'(i), 0, '0, 0, 0);
        step(0, 1, 64'h99, 0, '0, 0, 1);   // set and clear together: set wins
        for (int i = 0; i < 17; i++)
            step(0, 0, '0, 1, (i % 2 == 0) ? mtop(0, 0) : mtop(1, 0), 0, 0);
        step(0, 0, '0, 0, '0, 0, 1);       // clear sticky flags

        // Replace-top, push+pop on empty, then clear.
        step(0, 1, 64'h50, 0, '0, 0, 0);
        step(0, 1, 64'h60, 1, 64'h50, 0, 0);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 1, 64'h70, 1, 64'h0, 0, 0);
        step(0, 1, 64'h80, 1, 64'h0, 1, 0); // clr beats push/pop

        // Reset with ops pending.
        step(1, 0, '0, 1, 64'h5, 0, 0);
        do_reset(1);

        // Randomized traffic in phases biased toward fill or drain.
        for (int ph = 0; ph < 8; ph++) begin
            int push_pct = (ph % 2 == 0) ? 75 : 25;
            for (int n = 0; n < 80; n++) begin
                int ch = $urandom_range(NCH-1);
                int r = $urandom_range(99);
                bit push = ($urandom_range(99) < push_pct);
                bit pop  = ($urandom_range(99) < (100 - push_pct) / 2 + 10);
                bit clr  = (r < 2);
                bit eclr = ($urandom_range(99) < 5);
                logic [DW-1:0] pd = {$urandom, $urandom};
                logic [DW-1:0] cd = ($urandom_range(99) < 70) ?
                                    mtop($urandom_range(1), ch) : {32'h0, $urandom};
                step(ch, push, pd, pop, cd, clr, eclr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ras_shadow_stack_mc.md
RAS_SHADOW_STACK_MC -- requirements
Module: ras_shadow_stack_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 64, return-address width.
REQ-002 SHALL have parameter DEPTH, default 16, entries per channel; power of two, >=2.
REQ-003 SHALL have parameter NUM_CH, default 2, independent stacks (one per hart/privilege context); CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter OVERWRITE, default 0; 0 = drop push when full, 1 = overwrite oldest entry.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 i_ch  input  CH_W  channel selected for this cycle's push/pop/clear.
REQ-008 i_push  input  1  push i_push_data onto selected channel (call).
REQ-009 i_push_data  input  DATA_W  return address to push.
REQ-010 i_pop  input  1  pop selected channel and check (return).
REQ-011 i_chk_data  input  DATA_W  actual return target compared against popped entry.
REQ-012 i_clr  input  1  empty selected channel; highest priority over push/pop.
REQ-013 i_err_clr  input  1  clear sticky error flags.
REQ-014 o_top  output  DATA_W  combinational top entry of selected channel; 0 when empty.
REQ-015 o_full  output  NUM_CH  per-channel count == DEPTH.
REQ-016 o_empty  output  NUM_CH  per-channel count == 0.
REQ-017 o_chk_valid  output  1  registered pulse, one cycle after each accepted i_pop.
REQ-018 o_chk_fail  output  1  qualified by o_chk_valid; 1 = mismatch or underflow.
REQ-019 o_err_overflow  output  1  sticky; push attempted on a full channel.
REQ-020 o_err_underflow  output  1  sticky; pop attempted on an empty channel.

Function
REQ-021 Each channel SHALL hold a circular array of DEPTH entries, a top pointer wp (clog2(DEPTH) bits, wraps modulo DEPTH), and a count (clog2(DEPTH+1) bits); the top entry is mem[wp-1].
REQ-022 Push only, not full: mem[wp] <= i_push_data, wp+1, count+1.
REQ-023 Push only, full, OVERWRITE=0: no state change; o_err_overflow <= 1.
REQ-024 Push only, full, OVERWRITE=1: write mem[wp], wp+1, count held at DEPTH (oldest lost); o_err_overflow <= 1.
REQ-025 Pop only, not empty: wp-1, count-1; next cycle o_chk_valid=1, o_chk_fail = (top != i_chk_data) as sampled at the pop edge.
REQ-026 Pop only, empty: pointers unchanged; next cycle o_chk_valid=1, o_chk_fail=1; o_err_underflow <= 1.
REQ-027 Push+pop, not empty: check the current top as in REQ-025, then replace the top (mem[wp-1] <= i_push_data); wp and count unchanged.
REQ-028 Push+pop, empty: underflow as in REQ-026, then the push proceeds as in REQ-022.
REQ-029 i_clr: selected channel wp<=0, count<=0; push/pop ignored that cycle, o_chk_valid=0 next cycle, no error set.
REQ-030 Operations SHALL affect only channel i_ch; other channels hold state.
REQ-031 i_err_clr SHALL clear both sticky flags unless the same cycle sets one; set wins.
REQ-032 o_full/o_empty SHALL be combinational from count with zero latency.
REQ-033 Storage SHALL be inferable as distributed RAM (one write port, combinational read).

Reset
REQ-034 With rstn=0 at an edge: all wp and count = 0, o_empty = all 1, o_full = 0, o_chk_valid = 0, o_chk_fail = 0, both error flags = 0; memory contents need not be reset.
REQ-035 Reset SHALL override any simultaneous push/pop/clr; a pending check result SHALL be dropped.

Verification
REQ-036 Ch0 push 0x1000, 0x2000; pop with chk 0x2000 -> o_chk_valid=1, o_chk_fail=0; o_top=0x1000.
REQ-037 Ch0 push 0xA0, pop with chk 0xB0 -> o_chk_fail=1; push 0x1 to ch1, pop ch0 again -> ch1 count stays 1.
REQ-038 DEPTH=16, OVERWRITE=0: push 17 values 1..17 -> o_full[0]=1, o_top=16, o_err_overflow=1; 16 pops return 16..1 with no fail.
REQ-039 OVERWRITE=1: push 1..17 -> o_top=17, count 16; 16 pops check 17..2 pass, 17th pop -> fail and o_err_underflow=1.
REQ-040 Top=0x50; push+pop with data 0x60, chk 0x50 -> pass, o_top=0x60, count unchanged; then i_clr -> o_empty[0]=1.
REQ-041 Pop with rstn=0 in the same cycle -> o_chk_valid=0 next cycle, all flags 0.
